// File: rtl/qspi_master_ctrl.sv
// qspi_master_ctrl: single/dual/quad SPI master, MSB first, mode-0 sclk,
// multi-word bursts under one cs_n. Optional macro QSPI_LOOPBACK_EN.
//
// Ports (clock / reset):
//   i_clk, i_reset         system clock; async active-high reset
// Ports (host side):
//   i_start                begin a transfer (sampled in IDLE only)
//   i_lane_mode            0 single, 1 dual, 2/3 quad (latched at start)
//   i_num_words            burst length minus one (latched at start)
//   i_tx_data, o_tx_ready  word to send; loaded while o_tx_ready=1
//   o_rx_data, o_rx_valid  received word and its 1-cycle strobe
//   o_busy, o_done         transfer in progress / end-of-transfer pulse
// Ports (pad side):
//   o_sclk, o_cs_n         serial clock and chip select
//   o_mosi, o_mosi_oe      IO lane outputs and per-lane output enables
//   i_miso                 IO lane inputs
module qspi_master_ctrl #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2,
  parameter int CNT_W   = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [1:0]        i_lane_mode,
  input  logic [CNT_W-1:0]  i_num_words,
  input  logic [DATA_W-1:0] i_tx_data,
  output logic              o_tx_ready,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_sclk,
  output logic              o_cs_n,
  output logic [3:0]        o_mosi,
  output logic [3:0]        o_mosi_oe,
  input  logic [3:0]        i_miso
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SL_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE, CS_SETUP, SHIFT, CS_HOLD
  } state_t;

  state_t r_state, w_next;

  logic [1:0]        r_mode;
  logic [CNT_W-1:0]  r_words;
  logic [DIV_W-1:0]  r_div;
  logic [SL_W-1:0]   r_slot;
  logic [DATA_W-1:0] r_tx, r_rx, r_rx_data;
  logic              r_rx_valid, r_busy, r_done;
  logic              r_sclk, r_cs_n;

  logic              w_tick, w_rise, w_fall;
  logic              w_last_slot, w_last_word;
  logic              w_load, w_done_set, w_active;
  logic [1:0]        w_mode_eff;
  logic [SL_W-1:0]   w_slot_init;
  logic [3:0]        w_bits, w_oe, w_lanes;
  logic              w_sbit;
  logic [DATA_W-1:0] w_tx_shift, w_rx_shift;

  assign w_tick      = r_div == DIV_W'(CLK_DIV - 1);
  assign w_rise      = (r_state == SHIFT) && w_tick && !r_sclk;
  assign w_fall      = (r_state == SHIFT) && w_tick && r_sclk;
  assign w_last_slot = r_slot == '0;
  assign w_last_word = r_words == '0;
  assign w_active    = (r_state == CS_SETUP) || (r_state == SHIFT);

  // First word takes its mode from the port, later words from the latch.
  assign w_mode_eff = (r_state == IDLE) ? i_lane_mode : r_mode;

  always_comb begin
    w_slot_init = SL_W'(DATA_W - 1);
    unique case (1'b1)
      w_mode_eff[1]:          w_slot_init = SL_W'(DATA_W / 4 - 1);
      (w_mode_eff == 2'b01):  w_slot_init = SL_W'(DATA_W / 2 - 1);
      default: ;
    endcase
  end

  always_comb begin
    w_bits     = {3'b000, r_tx[DATA_W-1]};
    w_oe       = 4'b0001;
    w_tx_shift = r_tx << 1;
    w_rx_shift = (r_rx << 1) | DATA_W'(w_sbit);
    unique case (1'b1)
      r_mode[1]: begin
        w_bits     = r_tx[DATA_W-1 -: 4];
        w_oe       = 4'b1111;
        w_tx_shift = r_tx << 4;
        w_rx_shift = (r_rx << 4) | DATA_W'(w_lanes);
      end
      (r_mode == 2'b01): begin
        w_bits     = {2'b00, r_tx[DATA_W-1 -: 2]};
        w_oe       = 4'b0011;
        w_tx_shift = r_tx << 2;
        w_rx_shift = (r_rx << 2) | DATA_W'(w_lanes[1:0]);
      end
      default: ;
    endcase
  end

  assign o_mosi    = w_active ? w_bits : 4'b0000;
  assign o_mosi_oe = w_active ? w_oe : 4'b0000;

`ifdef QSPI_LOOPBACK_EN
  // Sample path reads back what we drive; disabled lanes read 0.
  assign w_lanes = o_mosi & o_mosi_oe;
  assign w_sbit  = w_lanes[0];
`else
  assign w_lanes = i_miso;
  assign w_sbit  = i_miso[1];
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_done_set = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          w_next = CS_SETUP;
          w_load = 1'b1;
        end
      end
      CS_SETUP: if (w_tick) w_next = SHIFT;
      SHIFT: begin
        if (w_fall && w_last_slot) begin
          if (w_last_word) w_next = CS_HOLD;
          else             w_load = 1'b1;
        end
      end
      CS_HOLD: begin
        if (w_tick) begin
          w_next     = IDLE;
          w_done_set = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign o_tx_ready = w_load;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_mode     <= '0;
      r_words    <= '0;
      r_div      <= '0;
      r_slot     <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sclk     <= 1'b0;
      r_cs_n     <= 1'b1;
    end else begin
      r_rx_valid <= 1'b0;
      r_done     <= 1'b0;
      if (r_state == IDLE || w_tick) r_div <= '0;
      else                           r_div <= r_div + 1'b1;
      if (w_load) begin
        r_tx   <= i_tx_data;
        r_slot <= w_slot_init;
      end
      if (r_state == IDLE && i_start) begin
        r_mode  <= i_lane_mode;
        r_words <= i_num_words;
        r_busy  <= 1'b1;
        r_cs_n  <= 1'b0;
        r_rx    <= '0;
      end
      if (w_rise) begin
        r_sclk <= 1'b1;
        r_rx   <= w_rx_shift;
        if (w_last_slot) begin
          r_rx_data  <= w_rx_shift;
          r_rx_valid <= 1'b1;
        end
      end
      if (w_fall) begin
        r_sclk <= 1'b0;
        if (w_last_slot) begin
          if (!w_last_word) r_words <= r_words - 1'b1;
        end else begin
          r_slot <= r_slot - 1'b1;
          r_tx   <= w_tx_shift;
        end
      end
      if (w_done_set) begin
        r_cs_n <= 1'b1;
        r_done <= 1'b1;
        r_busy <= 1'b0;
      end
    end
  end

  assign o_rx_data  = r_rx_data;
  assign o_rx_valid = r_rx_valid;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_sclk     = r_sclk;
  assign o_cs_n     = r_cs_n;

endmodule

// File: tb/tb_qspi_master_ctrl.sv
// Bench for qspi_master_ctrl: timeline model of each transfer
// computed from slot/period arithmetic, checked every cycle.
module tb_qspi_master_ctrl;
  localparam int DW = 8;
  localparam int CD = 2;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    lane_mode;
  logic [CW-1:0] num_words;
  logic [DW-1:0] tx_data;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid, busy, done, sclk, cs_n;
  logic [3:0]    mosi, mosi_oe, miso;

  always #5 clk = ~clk;

  qspi_master_ctrl #(.DATA_W(DW), .CLK_DIV(CD), .CNT_W(CW)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start),
    .i_lane_mode(lane_mode), .i_num_words(num_words),
    .i_tx_data(tx_data), .o_tx_ready(tx_ready),
    .o_rx_data(rx_data), .o_rx_valid(rx_valid),
    .o_busy(busy), .o_done(done), .o_sclk(sclk), .o_cs_n(cs_n),
    .o_mosi(mosi), .o_mosi_oe(mosi_oe), .i_miso(miso)
  );

  int n_cmp = 0;
  int n_fail = 0;
  logic [DW-1:0] tw[16];
  logic [DW-1:0] rw[16];
  int c_cs, c_rise, c_done, c_rxv, c_txr;
  logic [DW-1:0] obs;
  logic prev_sclk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] sbits(logic [DW-1:0] w, int s, int l);
    logic [DW-1:0] t;
    t = w >> (DW - l * (s + 1));
    return 4'(t & DW'((1 << l) - 1));
  endfunction

  function automatic logic [DW-1:0] exp_rx(int w);
`ifdef QSPI_LOOPBACK_EN
    return tw[w];
`else
    return rw[w];
`endif
  endfunction

  // k counts clock edges since the cycle start was applied (k=0).
  task automatic run_xfer(input int mode, input int nw,
                          input bit rnd_mid, input int abort_k);
    int l, spw, per, p, kd, mid_k;
    l   = (mode == 0) ? 1 : (mode == 1) ? 2 : 4;
    spw = DW / l;
    per = spw * 2 * CD;
    p   = per * (nw + 1);
    kd  = 2 * CD + p + 1;
    mid_k = rnd_mid ? $urandom_range(1, kd - 1) : -1;
    c_cs = 0; c_rise = 0; c_done = 0; c_rxv = 0; c_txr = 0;
    obs = '0; prev_sclk = 1'b0;
    for (int k = 0; k <= kd + 1; k++) begin
      bit in_set, in_sh, txr_e, rxv_e;
      int j, slot;
      logic [3:0] rb;
      in_set = (k >= 1) && (k <= CD);
      in_sh  = (k > CD) && (k <= CD + p);
      j      = k - CD - 1;
      slot   = in_sh ? j / (2 * CD) : 0;
      txr_e  = (k == 0) ||
               (k > CD && (k - CD) % per == 0 && (k - CD) / per <= nw);
      rxv_e  = (k > 1) && ((k - 1) % per == 0) &&
               ((k - 1) / per >= 1) && ((k - 1) / per <= nw + 1);
      @(negedge clk);
      start     = (k == 0) || (k == mid_k);
      lane_mode = (k == 0) ? 2'(mode) : 2'($urandom);
      num_words = (k == 0) ? CW'(nw) : CW'($urandom);
      if (!txr_e)      tx_data = DW'($urandom);
      else if (k == 0) tx_data = tw[0];
      else             tx_data = tw[(k - CD) / per];
      miso = 4'($urandom);
      if (in_sh) begin
        rb = sbits(rw[slot / spw], slot % spw, l);
        case (l)
          1:       miso[1]   = rb[0];
          2:       miso[1:0] = rb[1:0];
          default: miso      = rb;
        endcase
      end
      if (k == abort_k) begin
        reset = 1'b1;
        #1;
        chk("abort_cs_n", cs_n, 1);
        chk("abort_sclk", sclk, 0);
        chk("abort_oe", mosi_oe, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        for (int q = 0; q < 4; q++) begin
          @(negedge clk);
          #1;
          chk("abort_nodone", done, 0);
          chk("abort_idle_cs", cs_n, 1);
        end
        return;
      end
      #1;
      chk("cs_n", cs_n, !(k >= 1 && k <= 2 * CD + p));
      chk("busy", busy, (k >= 1 && k <= 2 * CD + p));
      chk("done", done, k == kd);
      chk("sclk", sclk, in_sh ? (j / CD) % 2 : 0);
      chk("mosi_oe", mosi_oe, (in_set || in_sh) ? (1 << l) - 1 : 0);
      if (in_set || in_sh)
        chk("mosi", mosi, sbits(tw[slot / spw], slot % spw, l));
      chk("tx_ready", tx_ready, txr_e);
      chk("rx_valid", rx_valid, rxv_e);
      if (rxv_e)
        chk("rx_data", rx_data, exp_rx((k - 1) / per - 1));
      if (k == kd)
        chk("rx_hold", rx_data, exp_rx(nw));
      if (!cs_n) c_cs++;
      if (sclk && !prev_sclk) c_rise++;
      prev_sclk = sclk;
      if (done) c_done++;
      if (rx_valid) c_rxv++;
      if (tx_ready) c_txr++;
      if (in_sh && (j % (2 * CD) == 0))
        obs = (obs << l) | DW'(mosi & 4'((1 << l) - 1));
    end
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; lane_mode = '0;
    num_words = '0; tx_data = '0; miso = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_oe", mosi_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_txr", tx_ready, 0);
    chk("rst_rxv", rx_valid, 0);
    chk("rst_rxd", rx_data, 0);
    reset = 1'b0;

    tw[0] = 8'hA5; rw[0] = 8'h3C;
    run_xfer(2, 0, 0, -1);
    chk("lit_q_mosi", obs, 8'hA5);
    chk("lit_q_cs", c_cs, 12);
    chk("lit_q_rise", c_rise, 2);
    chk("lit_q_done", c_done, 1);
    chk("lit_q_rxv", c_rxv, 1);
`ifndef QSPI_LOOPBACK_EN
    chk("lit_q_rx", rx_data, 8'h3C);
`endif

    tw[0] = 8'hA5; rw[0] = 8'h69;
    run_xfer(0, 0, 0, -1);
    chk("lit_s_mosi", obs, 8'hA5);
    chk("lit_s_rise", c_rise, 8);
`ifndef QSPI_LOOPBACK_EN
    chk("lit_s_rx", rx_data, 8'h69);
`endif

    tw[0] = 8'h12; tw[1] = 8'h34; tw[2] = 8'h56;
    rw[0] = 8'h9A; rw[1] = 8'hBC; rw[2] = 8'hDE;
    run_xfer(1, 2, 0, -1);
    chk("lit_d_txr", c_txr, 3);
    chk("lit_d_rxv", c_rxv, 3);
    chk("lit_d_cs", c_cs, 52);
    chk("lit_d_rise", c_rise, 12);
    chk("lit_d_done", c_done, 1);
    chk("lit_d_busy", busy, 0);

    for (int i = 0; i < 4; i++) begin
      tw[i] = DW'($urandom); rw[i] = DW'($urandom);
    end
    run_xfer(2, 3, 0, 14);
    tw[0] = 8'h5A; rw[0] = 8'hE1;
    run_xfer(3, 0, 0, -1);
    chk("post_abort_done", c_done, 1);

`ifdef QSPI_LOOPBACK_EN
    tw[0] = 8'hC3; rw[0] = 8'hFF;
    run_xfer(2, 0, 0, -1);
    chk("lit_lb_rx", rx_data, 8'hC3);
`endif

    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 4; i++) begin
        tw[i] = DW'($urandom); rw[i] = DW'($urandom);
      end
      run_xfer($urandom_range(0, 3), $urandom_range(0, 3), 1, -1);
      chk("rnd_done", c_done, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
